// File: rtl/spi_synth_controller.sv
// spi_synth_controller
//   Wishbone-programmed SPI master for synthesizer-style devices: shifts one
//   DATA_W word out MSB first, samples readback on spi_miso, then pulses a
//   per-device latch enable.
// Ports:
//   wb_clk_i, wb_rst_n_i       clock, async active-low reset
//   wb_adr_i..wb_stb_i         wishbone slave request
//   wb_dat_o, wb_ack_o, wb_err_o  wishbone slave response
//   spi_sclk, spi_mosi, spi_miso  serial bus (sclk idles low)
//   spi_le[NUM_CS-1:0]         latch enable, one per device
//   spi_ce                     device chip enable (mirrors CTRL.ce)
// Registers (wb_adr_i[3:2]): 0 TXDATA(W) 1 RXDATA(R) 2 CTRL(R/W) 3 STATUS(R/W1C)
module spi_synth_controller #(
   parameter int DATA_W = 32,
   parameter int NUM_CS = 2,
   parameter int DIV_W  = 8
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n_i,
   input  logic [31:0]       wb_adr_i,
   input  logic [31:0]       wb_dat_i,
   input  logic [3:0]        wb_sel_i,
   input  logic              wb_we_i,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   output logic [31:0]       wb_dat_o,
   output logic              wb_ack_o,
   output logic              wb_err_o,
   output logic              spi_sclk,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic [NUM_CS-1:0] spi_le,
   output logic              spi_ce
);
   localparam int BW = $clog2(DATA_W);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, LATCH} state_t;

   state_t            state;
   logic [DIV_W-1:0]  ctrl_div, div_q, cnt;
   logic [2:0]        ctrl_cs, cs_q;
   logic              ctrl_ce;
   logic              done, overrun, ph;
   logic [BW-1:0]     bit_cnt;
   logic [DATA_W-1:0] tx_reg, tx_sh, rx_sh, rx_reg, tx_new;
   logic [31:0]       ctrl_rd, ctrl_new, rdata;
   logic [NUM_CS-1:0] le_dec;

   logic busy, req, wr, wr_tx, wr_ctrl, wr_stat;
   assign busy    = (state != IDLE);
   assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   // Writes commit on the ack cycle (bus still holds the request), so the
   // transfer enters SETUP on the cycle right after the ack.
   assign wr      = wb_ack_o & wb_cyc_i & wb_stb_i & wb_we_i;
   assign wr_tx   = wr & (wb_adr_i[3:2] == 2'd0);
   assign wr_ctrl = wr & (wb_adr_i[3:2] == 2'd2);
   assign wr_stat = wr & (wb_adr_i[3:2] == 2'd3);
   assign wb_err_o = 1'b0;
   assign spi_ce   = ctrl_ce;

   always_comb begin
      ctrl_rd = '0;
      ctrl_rd[DIV_W-1:0] = ctrl_div;
      ctrl_rd[18:16]     = ctrl_cs;
      ctrl_rd[24]        = ctrl_ce;
      ctrl_new = ctrl_rd;
      for (int i = 0; i < 32; i++)
         if (wb_sel_i[i/8]) ctrl_new[i] = wb_dat_i[i];
      tx_new = tx_reg;
      for (int i = 0; i < DATA_W; i++)
         if (wb_sel_i[i/8]) tx_new[i] = wb_dat_i[i];
   end

   always_comb begin
      rdata = '0;
      case (wb_adr_i[3:2])
         2'd1:    rdata[DATA_W-1:0] = rx_reg;
         2'd2:    rdata = ctrl_rd;
         2'd3:    rdata[2:0] = {overrun, done, busy};
         default: rdata = '0;
      endcase
   end

   // Out-of-range cs leaves every latch enable low.
   always_comb begin
      le_dec = '0;
      for (int i = 0; i < NUM_CS; i++)
         if (cs_q == 3'(i)) le_dec[i] = 1'b1;
   end

   logic unused_bits;
   assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], ctrl_new};

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state    <= IDLE;
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
         ctrl_div <= DIV_W'(8'h0F);
         ctrl_cs  <= '0;
         ctrl_ce  <= 1'b1;
         div_q    <= '0;
         cs_q     <= '0;
         cnt      <= '0;
         bit_cnt  <= '0;
         ph       <= 1'b0;
         done     <= 1'b0;
         overrun  <= 1'b0;
         tx_reg   <= '0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         rx_reg   <= '0;
         spi_sclk <= 1'b0;
         spi_mosi <= 1'b0;
         spi_le   <= '0;
      end else begin
         wb_ack_o <= req;
         wb_dat_o <= req ? rdata : '0;

         if (wr_ctrl) begin
            ctrl_div <= ctrl_new[DIV_W-1:0];
            ctrl_cs  <= ctrl_new[18:16];
            ctrl_ce  <= ctrl_new[24];
         end
         if (wr_stat && wb_sel_i[0]) begin
            if (wb_dat_i[1]) done    <= 1'b0;
            if (wb_dat_i[2]) overrun <= 1'b0;
         end
         // Sets below are placed after the W1C so a coincident set wins.
         if (wr_tx && busy) overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (wr_tx) begin
                  state    <= SETUP;
                  tx_reg   <= tx_new;
                  tx_sh    <= tx_new;
                  spi_mosi <= tx_new[DATA_W-1];
                  div_q    <= ctrl_div;
                  cs_q     <= ctrl_cs;
                  cnt      <= ctrl_div;
                  bit_cnt  <= '0;
                  spi_sclk <= 1'b0;
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  state    <= SHIFT;
                  cnt      <= div_q;
                  ph       <= 1'b0;
                  spi_sclk <= 1'b1;
                  rx_sh    <= {rx_sh[DATA_W-2:0], spi_miso};
               end else cnt <= cnt - 1'b1;
            end
            SHIFT: begin
               // Counter reloads at every phase boundary: no cumulative drift.
               if (cnt == '0) begin
                  cnt <= div_q;
                  if (!ph) begin
                     ph       <= 1'b1;
                     spi_sclk <= 1'b0;
                     tx_sh    <= tx_sh << 1;
                     spi_mosi <= tx_sh[DATA_W-2];
                  end else if (bit_cnt == BW'(DATA_W-1)) begin
                     state    <= LATCH;
                     spi_le   <= le_dec;
                  end else begin
                     bit_cnt  <= bit_cnt + BW'(1);
                     ph       <= 1'b0;
                     spi_sclk <= 1'b1;
                     rx_sh    <= {rx_sh[DATA_W-2:0], spi_miso};
                  end
               end else cnt <= cnt - 1'b1;
            end
            LATCH: begin
               if (cnt == '0) begin
                  state    <= IDLE;
                  spi_le   <= '0;
                  spi_mosi <= 1'b0;
                  rx_reg   <= rx_sh;
                  done     <= 1'b1;
               end else cnt <= cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/spi_synth_controller.md
SPI_SYNTH_CONTROLLER -- requirements
Module: spi_synth_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning SPI word length in bits (legal 8..32).
REQ-002 SHALL have parameter NUM_CS, default 2, meaning number of independent latch-enable outputs (legal 1..8).
REQ-003 SHALL have parameter DIV_W, default 8, meaning width of the programmable half-period divider.
REQ-004 SHALL have wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have wb_rst_n_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have wishbone slave ports wb_adr_i in 32, wb_dat_i in 32, wb_sel_i in 4, wb_we_i in 1, wb_cyc_i in 1, wb_stb_i in 1, wb_dat_o out 32, wb_ack_o out 1, wb_err_o out 1.
REQ-007 SHALL have spi_sclk out 1 (serial clock, idle low), spi_mosi out 1 (serial data, MSB first), spi_miso in 1 (readback data), spi_le out NUM_CS (active-high latch enable per device), spi_ce out 1 (device chip enable).

Function
REQ-008 SHALL decode registers on wb_adr_i[3:2]: 0 TXDATA (W), 1 RXDATA (R), 2 CTRL (R/W), 3 STATUS (R/W1C).
REQ-009 SHALL define CTRL: [DIV_W-1:0] div; [18:16] cs index; [24] ce; reset value div=0x0F, cs=0, ce=1.
REQ-010 SHALL define STATUS: bit0 busy (RO), bit1 done (sticky), bit2 overrun (sticky); writing 1 clears bits 1/2.
REQ-011 SHALL assert wb_ack_o for exactly one cycle, one cycle after a cycle with wb_cyc_i&wb_stb_i&!wb_ack_o; no back-to-back acks.
REQ-012 SHALL honour wb_sel_i byte lanes on CTRL and TXDATA writes.
REQ-013 SHALL drive wb_dat_o with register contents (unused bits zero) only while wb_ack_o is high, else zero; wb_err_o tied 0.
REQ-014 SHALL start a transfer on a TXDATA write ack when busy=0; a TXDATA write while busy=1 SHALL be ignored and set overrun.
REQ-015 SHALL capture TXDATA[DATA_W-1:0], div and cs at transfer start; CTRL writes during a transfer take effect only at the next transfer.
REQ-016 SHALL implement states IDLE, SETUP, SHIFT, LATCH; half-period H = div+1 wb_clk_i cycles.
REQ-017 SHALL enter SETUP the cycle after the TXDATA ack, set busy, drive spi_mosi=MSB, sclk low, for H cycles.
REQ-018 SHALL in SHIFT emit DATA_W sclk periods (H low then H high per bit... low phase first after SETUP is replaced by SETUP: each bit = H high then H low); sample spi_miso on each sclk rising edge; update spi_mosi on each sclk falling edge.
REQ-019 SHALL in LATCH hold sclk low and assert spi_le[cs] high for H cycles; all other spi_le bits stay low; cs >= NUM_CS drives no spi_le.
REQ-020 SHALL at LATCH exit load RXDATA with the DATA_W sampled bits (first sample in MSB), set done, clear busy, return to IDLE.
REQ-021 SHALL complete a transfer in exactly (2*DATA_W+2)*H cycles from the cycle after the TXDATA ack to busy low.
REQ-022 SHALL drive spi_ce = CTRL.ce at all times, independent of state.
REQ-023 SHALL keep the divider counter free of drift: counter reloads at each phase boundary; div=0 yields sclk = wb_clk_i/2.

Reset
REQ-024 SHALL, on wb_rst_n_i low, immediately force state IDLE, spi_sclk=0, spi_mosi=0, spi_le=0, wb_ack_o=0, wb_dat_o=0, RXDATA=0, STATUS=0, CTRL to reset value, spi_ce=1.
REQ-025 SHALL abort any transfer in progress on reset without asserting spi_le or updating RXDATA.
REQ-026 SHALL resume normal operation on the first clock edge after wb_rst_n_i deasserts.

Verification
REQ-027 SHALL test: DATA_W=32, div=0, cs=0, write TXDATA=0xA5F0_0013 -> 32 MOSI bits MSB first, spi_le[0] high 1 cycle, busy low 66 cycles after ack, done=1.
REQ-028 SHALL test: MISO model returning 0x1234_5678 -> RXDATA reads 0x1234_5678 after done.
REQ-029 SHALL test: div=3, cs=1 -> sclk period 8 cycles, only spi_le[1] pulses for 4 cycles, transfer length 264 cycles.
REQ-030 SHALL test: second TXDATA write while busy -> ignored, overrun=1, first transfer data unchanged; W1C 0x6 clears done/overrun.
REQ-031 SHALL test: reset asserted mid-SHIFT -> outputs zero asynchronously, no spi_le pulse, RXDATA=0, CTRL=0x0100_000F.
REQ-032 SHALL test: CTRL.div written mid-transfer -> current transfer keeps old timing, next uses new.
